// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered hs/vs/blank/line/frame strobes aligned with DrawX/DrawY.
// One register stage, free-running with no backpressure; define VGA_TIMING_FRAMECNT_EN to add a 16-bit frame_count.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_TIMING_FRAMECNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic {
        START = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    // START pins the count at (0,0) for one clock so the first frame_start follows reset release.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        if (state_q == START) begin
            state_d = RUN;
            hcnt_d  = '0;
            vcnt_d  = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end else begin
            hcnt_d = hcnt_q + 10'd1;
        end
    end

    // Decode the next count so the registered strobes land on the same edge as DrawX/DrawY.
    always_comb begin
        hs_d    = ~((hcnt_d >= HS_BEG) && (hcnt_d < HS_END));
        vs_d    = ~((vcnt_d >= VS_BEG) && (vcnt_d < VS_END));
        blank_d = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
        ls_d    = (hcnt_d == 10'd0);
        fs_d    = (hcnt_d == 10'd0) && (vcnt_d == 10'd0);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q <= START;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign DrawX       = hcnt_q;
    assign DrawY       = vcnt_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] frame_cnt_q;
    logic        frame_wrap;

    assign frame_wrap = (state_q == RUN) && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (16x10 clocks per frame) so whole frames stay cheap.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 5, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int NV = 16;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    logic       vga_clk;
    logic       reset;
    logic       hs, vs, blank, line_start, frame_start;
    logic [9:0] DrawX, DrawY;
`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] frame_count;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_cyc;
    logic [15:0] fc_model;
    vec_t        vecs[NV];
    int          hs_low_l0, vs_low_f0, blank_f0, ls_f0, fs_2f;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VGA_TIMING_FRAMECNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Reference: position is just the clock index since release folded onto the raster.
    function automatic obs_t model(input int n);
        obs_t o;
        int   x, y;
        x       = n % HT;
        y       = (n / HT) % VT;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.hs    = !(x >= HV + HF && x < HV + HF + HS);
        o.vs    = !(y >= VV + VF && y < VV + VF + VS);
        o.blank = (x < HV) && (y < VV);
        o.ls    = (x == 0);
        o.fs    = (x == 0) && (y == 0);
        return o;
    endfunction

    function automatic obs_t rst_obs();
        return '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, ls: 1'b0, fs: 1'b0};
    endfunction

    function automatic obs_t sample();
        return '{x: DrawX, y: DrawY, hs: hs, vs: vs, blank: blank, ls: line_start, fs: frame_start};
    endfunction

    function automatic vec_t mk(input int n, input int x, input int y, input logic h, input logic v,
                                input logic b, input logic l, input logic f);
        vec_t r;
        r.n   = n;
        r.exp = '{x: 10'(x), y: 10'(y), hs: h, vs: v, blank: b, ls: l, fs: f};
        return r;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d: got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b",
                     name, n_cyc, act.x, act.y, act.hs, act.vs, act.blank, act.ls, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.ls, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s n=%0d: got %0d, want %0d", name, n_cyc, act, exp);
        end
    endtask

    task automatic step_check(input string tag, input bit use_table);
        obs_t act;
        @(posedge vga_clk);
        @(negedge vga_clk);
        n_cyc++;
        if (n_cyc > 0 && n_cyc % FRAME == 0) fc_model++;
        act = sample();
        check(tag, act, model(n_cyc));
`ifdef VGA_TIMING_FRAMECNT_EN
        check_int("frame_count", int'(frame_count), int'(fc_model));
`endif
        if (use_table) begin
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].n == n_cyc) check($sformatf("vec%0d", i), act, vecs[i].exp);
            end
            if (n_cyc < HT && !act.hs) hs_low_l0++;
            if (n_cyc < FRAME && !act.vs) vs_low_f0++;
            if (n_cyc < FRAME && act.blank) blank_f0++;
            if (n_cyc < FRAME && act.ls) ls_f0++;
            if (n_cyc <= 2 * FRAME && act.fs) fs_2f++;
        end
    endtask

    // Called from just after a falling edge: reset lands strictly between clock edges.
    task automatic async_reset(input int delay_ns, input int hold_edges);
        #(delay_ns);
        reset = 1'b1;
        #1;
        check("async_reset", sample(), rst_obs());
        fc_model = '0;
        repeat (hold_edges) @(posedge vga_clk);
        @(negedge vga_clk);
        check("held_reset", sample(), rst_obs());
`ifdef VGA_TIMING_FRAMECNT_EN
        check_int("reset_frame_count", int'(frame_count), 0);
`endif
        reset = 1'b0;
        n_cyc = -1;
    endtask

    initial begin
        reset     = 1'b1;
        n_cyc     = -1;
        fc_model  = '0;
        hs_low_l0 = 0; vs_low_f0 = 0; blank_f0 = 0; ls_f0 = 0; fs_2f = 0;

        vecs[0]  = mk(0,    0, 0, 1, 1, 1, 1, 1);
        vecs[1]  = mk(7,    7, 0, 1, 1, 1, 0, 0);
        vecs[2]  = mk(8,    8, 0, 1, 1, 0, 0, 0);
        vecs[3]  = mk(9,    9, 0, 1, 1, 0, 0, 0);
        vecs[4]  = mk(10,  10, 0, 0, 1, 0, 0, 0);
        vecs[5]  = mk(12,  12, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(13,  13, 0, 1, 1, 0, 0, 0);
        vecs[7]  = mk(15,  15, 0, 1, 1, 0, 0, 0);
        vecs[8]  = mk(16,   0, 1, 1, 1, 1, 1, 0);
        vecs[9]  = mk(80,   0, 5, 1, 1, 0, 1, 0);
        vecs[10] = mk(99,   3, 6, 1, 0, 0, 0, 0);
        vecs[11] = mk(127, 15, 7, 1, 0, 0, 0, 0);
        vecs[12] = mk(128,  0, 8, 1, 1, 0, 1, 0);
        vecs[13] = mk(159, 15, 9, 1, 1, 0, 0, 0);
        vecs[14] = mk(160,  0, 0, 1, 1, 1, 1, 1);
        vecs[15] = mk(171, 11, 0, 0, 1, 0, 0, 0);

        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check("reset_state", sample(), rst_obs());
        reset = 1'b0;

        for (int k = 0; k <= 3 * FRAME + 20; k++) step_check("run", 1'b1);

        check_int("hs_low_line0", hs_low_l0, HS);
        check_int("vs_low_frame0", vs_low_f0, VS * HT);
        check_int("blank_frame0", blank_f0, HV * VV);
        check_int("line_start_frame0", ls_f0, VT);
        check_int("frame_start_2frames", fs_2f, 3);

`ifdef VGA_TIMING_FRAMECNT_EN
        force dut.frame_cnt_q = 16'hFFFF;
        fc_model = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        while (n_cyc < 4 * FRAME + 5) step_check("fc_wrap", 1'b0);
`endif

        // Mid-frame reset at a known raster position, then restart from (0,0).
        for (int k = 0; k < 2 * FRAME && !(n_cyc % FRAME == 3 * HT + 5); k++) step_check("seek", 1'b0);
        check("seek_pos", sample(), model(3 * HT + 5));
        async_reset(2, 2);
        step_check("restart", 1'b0);
        check_int("restart_frame_start", int'(frame_start), 1);
        for (int k = 0; k < FRAME + 2; k++) step_check("post_reset", 1'b0);

        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(1, 2 * FRAME));
            for (int k = 0; k < len; k++) step_check("rand_run", 1'b0);
            async_reset(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            for (int k = 0; k < 20; k++) step_check("rand_restart", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in clocks.
REQ-004 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, 480, active lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 vga_clk  input  1  pixel clock; all state updates on its rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 hs  output  1  horizontal sync, active-low.
REQ-012 vs  output  1  vertical sync, active-low.
REQ-013 blank  output  1  high = active video (pixel may be driven); low = blanking.
REQ-014 DrawX  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-015 DrawY  output  10  current vertical count, 0..V_TOTAL-1.
REQ-016 line_start  output  1  one-cycle pulse when DrawX==0.
REQ-017 frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0.

Function
REQ-018 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525); both SHALL fit in 10 bits.
REQ-019 Two-state FSM: START (first clock after reset release) -> RUN; RUN persists until reset.
REQ-020 In START, counters hold (0,0) and output registers load the decode of (0,0).
REQ-021 In RUN, hcount increments each clock; at H_TOTAL-1 it wraps to 0 and vcount increments; vcount at V_TOTAL-1 wraps to 0 on the same edge hcount wraps.
REQ-022 DrawX/DrawY SHALL equal the registered counters; hs, vs, blank, line_start, frame_start SHALL be registered decodes of the same count, cycle-aligned with DrawX/DrawY (zero relative skew, no combinational outputs).
REQ-023 hs low iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (default 656..751).
REQ-024 vs low iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (default 490..491), for the full line width.
REQ-025 blank high iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-026 Frame period SHALL be exactly H_TOTAL*V_TOTAL clocks (default 420000) with no dropped or repeated counts across wraps.

Reset
REQ-027 While reset high: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0, FSM=START.
REQ-028 Reset asserted mid-frame SHALL force these values immediately (asynchronously); after release, the sequence restarts at REQ-020, with frame_start asserted on the first clock.

Configuration
REQ-029 Macro VGA_TIMING_FRAMECNT_EN, when defined, adds output frame_count (16 bits): reset 0, increments on the edge where both counters wrap to (0,0), and wraps 65535->0.
REQ-030 Without VGA_TIMING_FRAMECNT_EN, frame_count and its register SHALL NOT exist; all other behaviour is identical.

Verification
REQ-031 Release reset, count clocks -> frame_start at cycle 0 and again at cycle 420000; line_start every 800 clocks.
REQ-032 Sample line 0 -> blank=1 for DrawX 0..639, 0 for 640..799; hs=0 exactly for DrawX 656..751 (96 clocks).
REQ-033 Sample full frame -> vs=0 exactly for DrawY 490..491 (1600 clocks); blank=0 for all DrawY >= 480.
REQ-034 At DrawX=799, DrawY=524 -> next clock DrawX=0, DrawY=0, frame_start=1, blank=1, hs=1, vs=1.
REQ-035 Assert reset at DrawX=300, DrawY=200 between clock edges -> outputs immediately at reset values; after release, DrawX/DrawY restart at (0,0) with frame_start=1.
REQ-036 With VGA_TIMING_FRAMECNT_EN defined, run 3 frames -> frame_count 0,1,2,3 at successive frame_start pulses; preload via force to 65535 -> wraps to 0.
